// File: rtl/otfc_stream_converter.sv
// -----------------------------------------------------------------------------
// rbr_pkg / otfc_stream_converter
//
// Purpose:
//   On-the-fly converter for the tail of MSD-first (online) arithmetic units.
//   It takes a stream of radix-2 signed digits, most significant digit first,
//   K digits per handshake. It keeps the classic Q / QM register pair, where
//   QM = Q - 2^-L. The result is therefore available in two's complement
//   without a carry-propagate adder.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse: initialise and begin a conversion (any state)
//   len        digits to convert, sampled on start (0 or >N_DIGITS -> N_DIGITS)
//   in_valid   digit group valid
//   in_ready   converter accepts a digit group (registered, high in CONVERT)
//   digit_in   digit group, index 0 is the most significant / earliest digit
//   out_valid  result available (registered, high in DONE)
//   out_ready  consumer accepts the result
//   q          converted value Q, two's complement, 1 sign + N_DIGITS fraction
//   qm         Q - 2^-L
//   busy       high in CONVERT or DONE
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds its payload stable
// while valid is high and ready is low. Ready never depends combinationally
// on valid.
// -----------------------------------------------------------------------------

package rbr_pkg;
  // Radix-2 signed digit, two-bit borrow-save form:
  //   plus & !minus -> +1, !plus & minus -> -1, 00 / 11 -> 0
  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;
endpackage

module otfc_stream_converter #(
  parameter int N_DIGITS = 8,
  parameter int K        = 1,
  localparam int WIDTH   = N_DIGITS + 1,
  localparam int LW      = $clog2(N_DIGITS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LW-1:0]                   len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  rbr_pkg::signed_digit [K-1:0]    digit_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                q,
  output logic [WIDTH-1:0]                qm,
  output logic                            busy
);

  // A group must never straddle the end of the operand.
  generate
    if (K < 1 || (N_DIGITS % K) != 0) begin : g_bad_k
      $error("otfc_stream_converter: K must divide N_DIGITS");
    end
  endgenerate

  // Initial register pair: Q = 0, QM = -1 (sign bit only).
  localparam logic [WIDTH-1:0] Q_INIT  = '0;
  localparam logic [WIDTH-1:0] QM_INIT = {1'b1, {N_DIGITS{1'b0}}};
  localparam logic [WIDTH-1:0] ONE_LSB = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  q_r;
  logic [WIDTH-1:0]  qm_r;
  logic [LW-1:0]     count;   // digits already appended
  logic [LW-1:0]     l_eff;   // latched effective length L

  // ---------------------------------------------------------------------------
  // Effective length: out-of-range requests mean "full length". Otherwise the
  // request is rounded up to whole groups. Because K divides N_DIGITS, the
  // rounded value never exceeds N_DIGITS.
  // ---------------------------------------------------------------------------
  logic [LW-1:0] len_eff_c;
  int            len_rounded;

  always_comb begin
    len_rounded = ((int'(len) + K - 1) / K) * K;
    len_eff_c   = LW'(N_DIGITS);
    if (len != '0 && int'(len) <= N_DIGITS) begin
      len_eff_c = LW'(len_rounded);
    end
  end

  // ---------------------------------------------------------------------------
  // Append chain: the K digits of a group are folded in index order. Each step
  // sees the Q/QM produced by the previous one. Digit i of the group lands at
  // fraction position count+1+i, which is bit N_DIGITS-1-i-count.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] qm_nxt;
  logic [WIDTH-1:0] mask;
  logic [LW-1:0]    sh;

  always_comb begin
    q_nxt  = q_r;
    qm_nxt = qm_r;
    mask   = '0;
    sh     = '0;
    for (int i = 0; i < K; i++) begin
      sh   = LW'(N_DIGITS - 1 - i) - count;
      mask = ONE_LSB << sh;
      if (digit_in[i].plus && !digit_in[i].minus) begin
        // +1: QM takes the old Q, and Q gains the bit.
        qm_nxt = q_nxt;
        q_nxt  = q_nxt | mask;
      end else if (!digit_in[i].plus && digit_in[i].minus) begin
        // -1: Q borrows from QM, and QM is unchanged.
        q_nxt  = qm_nxt | mask;
      end else begin
        // 0: Q is unchanged, and QM gains the bit.
        qm_nxt = qm_nxt | mask;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs. start wins over everything,
  // including a same-cycle in_valid and a pending result in DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q_r       <= Q_INIT;
      qm_r      <= QM_INIT;
      count     <= '0;
      l_eff     <= LW'(N_DIGITS);
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= CONVERT;
      q_r       <= Q_INIT;
      qm_r      <= QM_INIT;
      count     <= '0;
      l_eff     <= len_eff_c;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end

        CONVERT: begin
          if (in_valid && in_ready) begin
            q_r   <= q_nxt;
            qm_r  <= qm_nxt;
            count <= count + LW'(K);
            if (count + LW'(K) == l_eff) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          // Q/QM keep their final values after the result is taken.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign q  = q_r;
  assign qm = qm_r;

endmodule

// File: tb/tb_otfc_stream_converter.sv
// -----------------------------------------------------------------------------
// tb_otfc_stream_converter
//
// Two converters (K=1 and K=2, N_DIGITS=8) share clock and reset. Expected
// Q/QM come from the arithmetic value of the digit string: v = sum d_i*2^(L-i).
// Then Q = v*2^(N-L) and QM = (v-1)*2^(N-L), taken as 9-bit two's complement.
// -----------------------------------------------------------------------------
module tb_otfc_stream_converter;
  import rbr_pkg::*;

  localparam int N = 8;
  localparam int W = N + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT K=1
  logic                start1, in_valid1, out_ready1;
  logic [3:0]          len1;
  signed_digit [0:0]   digit1;
  logic                in_ready1, out_valid1, busy1;
  logic [W-1:0]        q1, qm1;

  otfc_stream_converter #(.N_DIGITS(N), .K(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .len(len1),
    .in_valid(in_valid1), .in_ready(in_ready1), .digit_in(digit1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .q(q1), .qm(qm1), .busy(busy1)
  );

  // ---------------------------------------------------------------- DUT K=2
  logic                start2, in_valid2, out_ready2;
  logic [3:0]          len2;
  signed_digit [1:0]   digit2;
  logic                in_ready2, out_valid2, busy2;
  logic [W-1:0]        q2, qm2;

  otfc_stream_converter #(.N_DIGITS(N), .K(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .len(len2),
    .in_valid(in_valid2), .in_ready(in_ready2), .digit_in(digit2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .q(q2), .qm(qm2), .busy(busy2)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];   // {q, qm} expected per conversion
  int          dig[N];     // current digit string, values -1/0/+1

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int len_v, input int k);
    if (len_v == 0 || len_v > N) return N;
    return ((len_v + k - 1) / k) * k;
  endfunction

  function automatic logic [17:0] model(input int l);
    int v, qi, qmi;
    v = 0;
    for (int i = 0; i < l; i++) v = v * 2 + dig[i];
    qi  = v * (1 << (N - l));
    qmi = (v - 1) * (1 << (N - l));
    return {9'(qi), 9'(qmi)};
  endfunction

  // Zero is sent as either 00 or 11 at random.
  function automatic signed_digit enc(input int d);
    signed_digit r;
    logic b;
    b = 1'($urandom_range(0, 1));
    if (d > 0)      begin r.plus = 1'b1; r.minus = 1'b0; end
    else if (d < 0) begin r.plus = 1'b0; r.minus = 1'b1; end
    else            begin r.plus = b;    r.minus = b;    end
    return r;
  endfunction

  function automatic void rand_digits();
    for (int i = 0; i < N; i++) dig[i] = int'($urandom_range(0, 2)) - 1;
  endfunction

  // {busy, in_ready, out_valid, q, qm}
  function automatic logic [20:0] obs(input int k);
    if (k == 1) return {busy1, in_ready1, out_valid1, q1, qm1};
    return {busy2, in_ready2, out_valid2, q2, qm2};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive(input int k, input logic s, input int len_v, input logic v,
                       input int g, input logic o);
    if (k == 1) begin
      start1 = s; len1 = 4'(len_v); in_valid1 = v; out_ready1 = o;
      digit1[0] = enc(dig[g]);
    end else begin
      start2 = s; len2 = 4'(len_v); in_valid2 = v; out_ready2 = o;
      digit2[0] = enc(dig[2*g]);
      digit2[1] = enc(dig[2*g+1]);
    end
  endtask

  // Full conversion. stall: random idle cycles between groups. hold: cycles
  // with out_ready low in DONE. sv: in_valid high alongside start (must be
  // dropped). extra: keep in_valid high after the last group. rel: take the
  // result with out_ready.
  task automatic convert(input int k, input int len_v, input bit stall, input int hold,
                         input bit sv, input bit extra, input bit rel);
    int          l, t;
    logic [20:0] o;
    logic [17:0] e;
    l = eff_len(len_v, k);
    @(posedge clk); #1 drive(k, 1'b1, len_v, sv, 0, 1'b0);
    @(posedge clk); #1 drive(k, 1'b0, len_v, 1'b0, 0, 1'b0);
    @(negedge clk);
    o = obs(k);
    check("start_busy",   32'(o[20]), 1);
    check("start_ready",  32'(o[19]), 1);
    check("start_ovalid", 32'(o[18]), 0);
    check("start_q",      32'(o[17:9]), 0);
    check("start_qm",     32'(o[8:0]), 32'h100);
    for (int g = 0; g < l / k; g++) begin
      if (stall && $urandom_range(0, 1) == 1) begin
        drive(k, 1'b0, len_v, 1'b0, g, 1'b0);
        @(posedge clk); @(negedge clk);
      end
      drive(k, 1'b0, len_v, 1'b1, g, 1'b0);
      t = 0;
      o = obs(k);
      while (!o[19] && t < 16) begin
        @(negedge clk);
        o = obs(k);
        t++;
      end
      if (!o[19]) check("hs_timeout", 0, 1);
      check("early_ovalid", 32'(o[18]), 0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(k, 1'b0, len_v, extra, 0, 1'b0);
    exp_q.push_back(model(l));
    o = obs(k);
    check("done_ovalid", 32'(o[18]), 1);
    check("done_ready",  32'(o[19]), 0);
    check("done_busy",   32'(o[20]), 1);
    e = exp_q.pop_front();
    check("q",  32'(o[17:9]), 32'(e[17:9]));
    check("qm", 32'(o[8:0]),  32'(e[8:0]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      o = obs(k);
      check("hold_ovalid", 32'(o[18]), 1);
      check("hold_ready",  32'(o[19]), 0);
      check("hold_q",      32'(o[17:9]), 32'(e[17:9]));
      check("hold_qm",     32'(o[8:0]),  32'(e[8:0]));
    end
    if (rel) begin
      drive(k, 1'b0, len_v, extra, 0, 1'b1);
      @(negedge clk);
      drive(k, 1'b0, len_v, 1'b0, 0, 1'b0);
      o = obs(k);
      check("rel_ovalid", 32'(o[18]), 0);
      check("rel_busy",   32'(o[20]), 0);
      check("rel_q",      32'(o[17:9]), 32'(e[17:9]));
      check("rel_qm",     32'(o[8:0]),  32'(e[8:0]));
    end else begin
      drive(k, 1'b0, len_v, 1'b0, 0, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [20:0] o_top;

  initial begin
    rst = 1'b1;
    start1 = 0; in_valid1 = 0; out_ready1 = 0; len1 = 0; digit1 = '0;
    start2 = 0; in_valid2 = 0; out_ready2 = 0; len2 = 0; digit2 = '0;
    for (int i = 0; i < N; i++) dig[i] = 0;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      o_top = obs(k);
      check("rst_busy",   32'(o_top[20]), 0);
      check("rst_ready",  32'(o_top[19]), 0);
      check("rst_ovalid", 32'(o_top[18]), 0);
      check("rst_q",      32'(o_top[17:9]), 0);
      check("rst_qm",     32'(o_top[8:0]), 32'h100);
    end
    rst = 1'b0;

    // Directed cases.
    dig = '{1, -1, 0, 0, 0, 0, 0, 0};
    convert(1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    dig = '{-1, -1, -1, -1, -1, -1, -1, -1};
    convert(1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    dig = '{0, 0, 0, 0, 0, 0, 0, 0};
    convert(1, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    dig = '{1, -1, 0, 0, 0, 0, 0, 0};
    convert(2, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    dig = '{1, 1, 1, 1, 0, 0, 0, 0};
    convert(1, 4, 1'b0, 3, 1'b0, 1'b1, 1'b1);
    dig = '{1, -1, 1, 1, -1, 0, 0, 0};
    convert(2, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    dig = '{-1, 1, 0, -1, 1, 1, 0, 0};
    convert(1, 12, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Abort after 3 digits; restart with start and in_valid together.
    rand_digits();
    @(negedge clk); drive(1, 1'b1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 1'b0, 0, 1'b1, i, 1'b0);
    end
    @(negedge clk); drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    rand_digits();
    convert(1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1);

    // start while a result is pending in DONE.
    rand_digits();
    convert(2, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    rand_digits();
    convert(2, 6, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Randomized conversions.
    for (int r = 0; r < 12; r++) begin
      rand_digits();
      convert(int'($urandom_range(1, 2)), int'($urandom_range(0, 10)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    // Asynchronous reset after 5 digits.
    rand_digits();
    @(negedge clk); drive(1, 1'b1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1, 1'b0, 0, 1'b1, i, 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    o_top = obs(1);
    check("arst_q",      32'(o_top[17:9]), 0);
    check("arst_qm",     32'(o_top[8:0]), 32'h100);
    check("arst_ovalid", 32'(o_top[18]), 0);
    check("arst_busy",   32'(o_top[20]), 0);
    check("arst_ready",  32'(o_top[19]), 0);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    o_top = obs(1);
    check("post_rst_busy", 32'(o_top[20]), 0);

    // Recovery after reset.
    rand_digits();
    convert(1, 0, 1'b1, 1, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
